output_frame_buffer: RTL and testbench

- Receive end of the CNN pixel path: collects the raster-ordered result stream from a conv/window stage (valid-only, no backpressure) into an on-chip frame buffer.
- Once a full IMG_WIDTH x IMG_HEIGHT frame is captured, replays it downstream over a valid/ready interface with SOF/EOL/EOF markers.
- Single buffer: fill and drain alternate; they never overlap.

---
 rtl/output_frame_buffer.sv | 115 +++++++++++
 tb/tb_output_frame_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/output_frame_buffer.sv
// output_frame_buffer: captures one raster frame into RAM, then replays it over valid/ready with SOF/EOL/EOF.
// Define OFB_RELU_EN to clamp negative (two's-complement) input pixels to zero on write.
module output_frame_buffer #(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              overflow
);
    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW = N > 1 ? $clog2(N) : 1;
    localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
    state_t state, state_d;

    logic [DATA_W-1:0] mem [N];
    logic [DATA_W-1:0] wr_data, q_data;
    logic [AW-1:0]     wr_cnt, rd_addr;
    logic [CW-1:0]     rd_col;
    logic [RW-1:0]     rd_row;
    logic              rd_left, q_v, q_sof, q_eol, q_eof;
    logic              wr_en, wr_last, rd_en, out_load, done;

`ifdef OFB_RELU_EN
    assign wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign wr_data = in_data;
`endif

    // The RAM output register holds its word until the output stage takes it,
    // acting as the skid entry that keeps one beat per clock under stalls.
    always_comb begin
        wr_en    = in_valid && state != DRAIN;
        wr_last  = wr_en && wr_cnt == A_LAST;
        out_load = q_v && (!out_valid || out_ready);
        rd_en    = state == DRAIN && rd_left && (!q_v || out_load);
        done     = out_valid && out_ready && out_eof;
        state_d  = wr_last ? DRAIN : wr_en ? FILL : done ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) q_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            wr_cnt    <= '0;
            rd_addr   <= '0;
            rd_col    <= '0;
            rd_row    <= '0;
            rd_left   <= 1'b0;
            q_v       <= 1'b0;
            q_sof     <= 1'b0;
            q_eol     <= 1'b0;
            q_eof     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            state    <= state_d;
            busy     <= state_d != IDLE;
            overflow <= overflow | (in_valid && state == DRAIN);
            if (wr_en) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
            if (wr_last) begin
                rd_addr <= '0;
                rd_col  <= '0;
                rd_row  <= '0;
                rd_left <= 1'b1;
            end else if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
                rd_col  <= rd_col == C_LAST ? '0 : rd_col + 1'b1;
                rd_row  <= rd_col == C_LAST ? rd_row + 1'b1 : rd_row;
                rd_left <= !(rd_col == C_LAST && rd_row == R_LAST);
            end
            if (rd_en) begin
                q_sof <= rd_col == '0 && rd_row == '0;
                q_eol <= rd_col == C_LAST;
                q_eof <= rd_col == C_LAST && rd_row == R_LAST;
            end
            q_v       <= rd_en ? 1'b1 : out_load ? 1'b0 : q_v;
            out_valid <= out_load ? 1'b1 : out_ready ? 1'b0 : out_valid;
            if (out_load) begin
                out_data <= q_data;
                out_sof  <= q_sof;
                out_eol  <= q_eol;
                out_eof  <= q_eof;
            end
        end
    end
endmodule

// File: tb/tb_output_frame_buffer.sv
// tb_output_frame_buffer: directed checks of fill/drain timing, flags, stalls, overflow, reset abort and ReLU.
module tb_output_frame_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sof, out_eol, out_eof, busy, overflow;

    int tests = 0;
    int fails = 0;
    logic [7:0] frame [12];
    logic [7:0] expv  [12];

    output_frame_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input int base);
        for (int i = 0; i < 12; i++) begin
            frame[i] = 8'(base + i);
            expv[i]  = 8'(base + i);
        end
    endtask

    task automatic send(input bit gap);
        for (int i = 0; i < 12; i++) begin
            if (gap && i % 2 == 1) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("fill_busy", 32'(busy), 1);
        chk("fill_no_valid", 32'(out_valid), 0);
    endtask

    // Starts on the negedge right after the last pixel was captured; first beat due on the 2nd negedge.
    task automatic drain(input bit rnd, input int inj, input int abort_at);
        int idx = 0, cyc = 0, first = -1;
        bit rdy, stall = 1'b0;
        logic [7:0] pd = '0;
        logic [2:0] pf = '0;
        while (idx < 12 && idx != abort_at && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid = (inj == 1 && cyc == 3);
            in_data  = 8'hAA;
            if (stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(pd));
                chk("hold_flags", 32'({out_sof, out_eol, out_eof}), 32'(pf));
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (out_valid) begin
                if (first < 0) begin
                    first = cyc;
                    chk("first_beat_cycle", 32'(cyc), 2);
                end
                if (rdy) begin
                    chk("data", 32'(out_data), 32'(expv[idx]));
                    chk("flags", 32'({out_sof, out_eol, out_eof}),
                        32'({idx == 0, idx % 4 == 3, idx == 11}));
                    if (!rnd && idx == 11) chk("last_beat_cycle", 32'(cyc), 13);
                    if (inj == 2 && idx == 11) in_valid = 1'b1;
                    idx++;
                end
            end
            stall = out_valid && !rdy;
            pd = out_data;
            pf = {out_sof, out_eol, out_eof};
        end
        if (abort_at < 0) begin
            chk("beat_count", 32'(idx), 12);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("end_valid", 32'(out_valid), 0);
            chk("end_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_flags", 32'({out_sof, out_eol, out_eof}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        set_frame(0);  send(1'b0); drain(1'b0, 0, -1);
        set_frame(0);  send(1'b1); drain(1'b0, 0, -1);
        set_frame(0);  send(1'b0); drain(1'b1, 0, -1);
        chk("no_overflow", 32'(overflow), 0);

        set_frame(0);  send(1'b0); drain(1'b0, 0, 6);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_data", 32'(out_data), 0);
        chk("abort_flags", 32'({out_sof, out_eol, out_eof}), 0);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_abort_valid", 32'(out_valid), 0);
        chk("post_abort_busy", 32'(busy), 0);
        set_frame(100); send(1'b0); drain(1'b0, 0, -1);

        set_frame(40); send(1'b0); drain(1'b0, 2, -1);
        chk("overflow_at_idle_edge", 32'(overflow), 1);

        set_frame(4);
        frame[0] = 8'h7F; frame[1] = 8'h80; frame[2] = 8'hFF; frame[3] = 8'h01;
`ifdef OFB_RELU_EN
        expv[0] = 8'h7F; expv[1] = 8'h00; expv[2] = 8'h00; expv[3] = 8'h01;
`else
        expv[0] = 8'h7F; expv[1] = 8'h80; expv[2] = 8'hFF; expv[3] = 8'h01;
`endif
        send(1'b0); drain(1'b0, 1, -1);
        chk("overflow_sticky", 32'(overflow), 1);

        set_frame(60); send(1'b1); drain(1'b1, 0, -1);
        chk("overflow_still", 32'(overflow), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
